// File: rtl/l2norm_stream_arbiter_if.sv
// rtl/l2norm_stream_arbiter_if.sv - AXI-Stream style handshake bundle shared by all arbiter streams
interface l2norm_stream_arbiter_if #(
  parameter int W = 64
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/l2norm_stream_arbiter.sv
// rtl/l2norm_stream_arbiter.sv - two-requester packet arbiter for a shared L2-norm core with result return
module l2norm_stream_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clock,
  input  logic                           reset,
  l2norm_stream_arbiter_if.slave         s0,
  l2norm_stream_arbiter_if.slave         s1,
  l2norm_stream_arbiter_if.master        m,
  l2norm_stream_arbiter_if.slave         core_res,
  l2norm_stream_arbiter_if.master        r0,
  l2norm_stream_arbiter_if.master        r1,
  output logic                           busy,
  output logic                           timeout_err,
  input  logic                           err_clr,
  output logic [15:0]                    res_cnt0,
  output logic [15:0]                    res_cnt1
);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        err_q, err_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] res_cnt0_q, res_cnt0_d;
  logic [15:0] res_cnt1_q, res_cnt1_d;

  logic own_valid, own_last, res_ready, err_set;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    res_cnt0_d   = res_cnt0_q;
    res_cnt1_d   = res_cnt1_q;
    err_set      = 1'b0;

    s0.tready       = 1'b0;
    s1.tready       = 1'b0;
    m.tdata         = '0;
    m.tvalid        = 1'b0;
    m.tlast         = 1'b0;
    r0.tdata        = '0;
    r0.tvalid       = 1'b0;
    r0.tlast        = 1'b0;
    r1.tdata        = '0;
    r1.tvalid       = 1'b0;
    r1.tlast        = 1'b0;
    core_res.tready = 1'b0;

    own_valid = owner_q ? s1.tvalid : s0.tvalid;
    own_last  = owner_q ? s1.tlast  : s0.tlast;
    res_ready = owner_q ? r1.tready : r0.tready;

    case (state_q)
      IDLE: begin
        // Results arriving with no packet outstanding are stale; swallow them.
        core_res.tready = 1'b1;
        if (s0.tvalid || s1.tvalid) begin
          owner_d = (s0.tvalid && s1.tvalid) ? ~last_grant_q : s1.tvalid;
          state_d = STREAM;
        end
      end
      STREAM: begin
        core_res.tready = 1'b1;
        m.tvalid        = own_valid;
        m.tlast         = own_last;
        m.tdata         = owner_q ? s1.tdata : s0.tdata;
        if (owner_q) s1.tready = m.tready;
        else         s0.tready = m.tready;
        if (own_valid && m.tready && own_last) begin
          state_d   = WAIT_RES;
          tmo_cnt_d = '0;
        end
      end
      WAIT_RES: begin
        core_res.tready = res_ready;
        if (owner_q) begin
          r1.tvalid = core_res.tvalid;
          r1.tdata  = core_res.tvalid ? core_res.tdata : '0;
          r1.tlast  = core_res.tvalid & core_res.tlast;
        end else begin
          r0.tvalid = core_res.tvalid;
          r0.tdata  = core_res.tvalid ? core_res.tdata : '0;
          r0.tlast  = core_res.tvalid & core_res.tlast;
        end
        // A handshake on the final allowed cycle still counts as delivered.
        if (core_res.tvalid && res_ready) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
          if (owner_q) res_cnt1_d = res_cnt1_q + 16'd1;
          else         res_cnt0_d = res_cnt0_q + 16'd1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
          err_set      = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) core_res.tready = 1'b0;

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      res_cnt0_q   <= '0;
      res_cnt1_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      tmo_cnt_q    <= tmo_cnt_d;
      res_cnt0_q   <= res_cnt0_d;
      res_cnt1_q   <= res_cnt1_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;
  assign res_cnt0    = res_cnt0_q;
  assign res_cnt1    = res_cnt1_q;
endmodule

// File: tb/tb_l2norm_stream_arbiter.sv
// tb/tb_l2norm_stream_arbiter.sv - directed self-checking bench for l2norm_stream_arbiter
module tb_l2norm_stream_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic [15:0] res_cnt0;
  logic [15:0] res_cnt1;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          b;

  l2norm_stream_arbiter_if #(.W(64)) s0_if ();
  l2norm_stream_arbiter_if #(.W(64)) s1_if ();
  l2norm_stream_arbiter_if #(.W(64)) m_if ();
  l2norm_stream_arbiter_if #(.W(32)) core_if ();
  l2norm_stream_arbiter_if #(.W(32)) r0_if ();
  l2norm_stream_arbiter_if #(.W(32)) r1_if ();

  l2norm_stream_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .s0          (s0_if),
    .s1          (s1_if),
    .m           (m_if),
    .core_res    (core_if),
    .r0          (r0_if),
    .r1          (r1_if),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .res_cnt0    (res_cnt0),
    .res_cnt1    (res_cnt1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    s0_if.tvalid = 0; s0_if.tdata = 0; s0_if.tlast = 0;
    s1_if.tvalid = 0; s1_if.tdata = 0; s1_if.tlast = 0;
    m_if.tready = 0;
    core_if.tvalid = 0; core_if.tdata = 0; core_if.tlast = 0;
    r0_if.tready = 0; r1_if.tready = 0;
    #1 reset = 1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_err", timeout_err, 0);
    check("rst_cnt0", res_cnt0, 0);
    check("rst_cnt1", res_cnt1, 0);
    check("rst_core_tready", core_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_s0_tready", s0_if.tready, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 0;

    // Contention after reset: s0 first, then s1 by round robin.
    s0_if.tvalid = 1; s0_if.tdata = 64'hA0;
    s1_if.tvalid = 1; s1_if.tdata = 64'hB0;
    m_if.tready = 1;
    #1 check("idle_s0_tready", s0_if.tready, 0);
    check("idle_core_tready", core_if.tready, 1);
    tick;
    for (int i = 0; i < 3; i++) begin
      s0_if.tdata = 64'hA0 + 64'(i); s0_if.tlast = (i == 2);
      #1 check("p0_m_tdata", m_if.tdata, 64'hA0 + 64'(i));
      check("p0_m_tlast", m_if.tlast, 64'(i == 2));
      check("p0_s1_tready", s1_if.tready, 0);
      tick;
    end
    s0_if.tdata = 64'hA3; s0_if.tlast = 1;
    core_if.tvalid = 1; core_if.tdata = 32'h19; r0_if.tready = 1; r1_if.tready = 1;
    #1 check("p0_r0_tvalid", r0_if.tvalid, 1);
    check("p0_r0_tdata", r0_if.tdata, 32'h19);
    check("p0_r1_tvalid", r1_if.tvalid, 0);
    check("p0_r1_tdata", r1_if.tdata, 0);
    check("p0_m_tvalid", m_if.tvalid, 0);
    tick;
    core_if.tvalid = 0;
    #1 check("p0_cnt0", res_cnt0, 1);
    check("p0_busy", busy, 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      s1_if.tdata = 64'hB0 + 64'(i); s1_if.tlast = (i == 2);
      #1 check("p1_m_tdata", m_if.tdata, 64'hB0 + 64'(i));
      check("p1_s0_tready", s0_if.tready, 0);
      tick;
    end
    s0_if.tvalid = 0; s1_if.tvalid = 0; s1_if.tlast = 0;
    core_if.tvalid = 1; core_if.tdata = 32'h2A;
    #1 check("p1_r1_tdata", r1_if.tdata, 32'h2A);
    check("p1_r0_tvalid", r0_if.tvalid, 0);
    tick;
    core_if.tvalid = 0;
    #1 check("p1_cnt1", res_cnt1, 1);
    check("p1_cnt0", res_cnt0, 1);

    // s1 streams under back-pressure while s0 waits.
    s1_if.tvalid = 1; s1_if.tdata = 64'hC0; m_if.tready = 0;
    tick;
    b = 0;
    for (int c = 0; c < 20 && b < 3; c++) begin
      m_if.tready = c[0];
      s1_if.tdata = 64'hC0 + 64'(b); s1_if.tlast = (b == 2);
      if (c == 1) begin
        s0_if.tvalid = 1; s0_if.tdata = 64'hD0; s0_if.tlast = 1;
      end
      #1 check("p2_s0_tready", s0_if.tready, 0);
      check("p2_m_tdata", m_if.tdata, 64'hC0 + 64'(b));
      check("p2_s1_tready", s1_if.tready, 64'(c[0]));
      tick;
      if (c[0]) b++;
    end
    check("p2_done", 64'(b), 3);
    s1_if.tvalid = 0; s1_if.tlast = 0; m_if.tready = 1;
    core_if.tvalid = 1; core_if.tdata = 32'h33;
    #1 check("p2_wait_s0_tready", s0_if.tready, 0);
    check("p2_r1_tdata", r1_if.tdata, 32'h33);
    check("p2_r0_tvalid", r0_if.tvalid, 0);
    tick;
    core_if.tvalid = 0;
    #1 check("p2_cnt1", res_cnt1, 2);
    check("p2_idle_s0_tready", s0_if.tready, 0);
    tick;
    #1 check("p3_s0_tready", s0_if.tready, 1);
    check("p3_m_tdata", m_if.tdata, 64'hD0);
    check("p3_m_tlast", m_if.tlast, 1);
    tick;
    s0_if.tvalid = 0; s0_if.tlast = 0;
    #1 check("p3_one_beat_busy", busy, 1);
    check("p3_m_tvalid", m_if.tvalid, 0);

    // Result held while r0 back-pressures.
    core_if.tvalid = 1; core_if.tdata = 32'h19; r0_if.tready = 0;
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_core_tready", core_if.tready, 0);
      check("bp_r0_tvalid", r0_if.tvalid, 1);
      check("bp_r0_tdata", r0_if.tdata, 32'h19);
      tick;
    end
    r0_if.tready = 1;
    #1 check("bp_release_core_tready", core_if.tready, 1);
    tick;
    core_if.tvalid = 0;
    #1 check("bp_cnt0", res_cnt0, 2);
    check("bp_busy", busy, 0);

    // Stray result in IDLE is consumed and hidden.
    core_if.tvalid = 1; core_if.tdata = 32'h77;
    #1 check("stray_core_tready", core_if.tready, 1);
    check("stray_r0_tvalid", r0_if.tvalid, 0);
    check("stray_r0_tdata", r0_if.tdata, 0);
    check("stray_r1_tvalid", r1_if.tvalid, 0);
    tick;
    core_if.tvalid = 0;
    #1 check("stray_cnt0", res_cnt0, 2);

    // Timeout after 8 cycles in WAIT_RES.
    s0_if.tvalid = 1; s0_if.tdata = 64'hE0; s0_if.tlast = 1;
    tick;
    tick;
    s0_if.tvalid = 0; s0_if.tlast = 0;
    for (int k = 1; k <= 7; k++) begin
      tick;
      #1 check("tmo_err_early", timeout_err, 0);
      check("tmo_busy_early", busy, 1);
    end
    tick;
    #1 check("tmo_err_set", timeout_err, 1);
    check("tmo_busy_clr", busy, 0);
    check("tmo_cnt0", res_cnt0, 2);
    err_clr = 1;
    tick;
    err_clr = 0;
    #1 check("tmo_err_cleared", timeout_err, 0);

    // Handshake on the last allowed cycle beats the timeout.
    s0_if.tvalid = 1; s0_if.tlast = 1;
    tick;
    tick;
    s0_if.tvalid = 0; s0_if.tlast = 0;
    repeat (7) tick;
    core_if.tvalid = 1; core_if.tdata = 32'h44;
    #1 check("edge_r0_tdata", r0_if.tdata, 32'h44);
    tick;
    core_if.tvalid = 0;
    #1 check("edge_err", timeout_err, 0);
    check("edge_cnt0", res_cnt0, 3);
    check("edge_busy", busy, 0);

    // Timeout coinciding with err_clr: set wins.
    s0_if.tvalid = 1; s0_if.tlast = 1;
    tick;
    tick;
    s0_if.tvalid = 0; s0_if.tlast = 0;
    repeat (7) tick;
    err_clr = 1;
    tick;
    err_clr = 0;
    #1 check("setwins_err", timeout_err, 1);
    err_clr = 1;
    tick;
    err_clr = 0;
    #1 check("setwins_cleared", timeout_err, 0);

    // Asynchronous reset mid-packet.
    s1_if.tvalid = 1; s1_if.tdata = 64'hF0; s1_if.tlast = 0;
    tick;
    #1 check("ar_s1_tready_pre", s1_if.tready, 1);
    #1 reset = 1;
    #1 check("ar_s1_tready", s1_if.tready, 0);
    check("ar_m_tvalid", m_if.tvalid, 0);
    check("ar_busy", busy, 0);
    check("ar_core_tready", core_if.tready, 0);
    check("ar_cnt0", res_cnt0, 0);
    check("ar_cnt1", res_cnt1, 0);
    check("ar_r1_tvalid", r1_if.tvalid, 0);
    @(negedge clock);
    reset = 0;
    s0_if.tvalid = 1; s0_if.tdata = 64'h1234; s0_if.tlast = 1;
    core_if.tvalid = 1; core_if.tdata = 32'h55;
    #1 check("ar_stray_r0_tvalid", r0_if.tvalid, 0);
    check("ar_stray_r1_tvalid", r1_if.tvalid, 0);
    check("ar_stray_core_tready", core_if.tready, 1);
    tick;
    core_if.tvalid = 0;
    #1 check("ar_grant_s0_tready", s0_if.tready, 1);
    check("ar_grant_s1_tready", s1_if.tready, 0);
    check("ar_grant_m_tdata", m_if.tdata, 64'h1234);
    tick;
    s0_if.tvalid = 0; s0_if.tlast = 0; s1_if.tvalid = 0;

    // Counter wrap from 0xFFFF.
    force dut.res_cnt0_q = 16'hFFFF;
    #1 release dut.res_cnt0_q;
    core_if.tvalid = 1; core_if.tdata = 32'h19;
    #1 check("wrap_r0_tdata", r0_if.tdata, 32'h19);
    tick;
    core_if.tvalid = 0;
    #1 check("wrap_cnt0", res_cnt0, 16'h0000);
    check("wrap_cnt1", res_cnt1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/l2norm_stream_arbiter.md
L2NORM_STREAM_ARBITER -- requirements
Module: l2norm_stream_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning max cycles in WAIT_RES before abort (legal 2..65535).
REQ-002 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports s0_tdata/s1_tdata  in  64  requester vector beats.
REQ-005 SHALL have ports s0_tvalid/s1_tvalid  in  1, s0_tlast/s1_tlast  in  1, s0_tready/s1_tready  out  1  requester AXIS handshake.
REQ-006 SHALL have ports m_tdata  out  64, m_tvalid  out  1, m_tlast  out  1, m_tready  in  1  shared L2-norm core input stream.
REQ-007 SHALL have ports core_res_tdata  in  32, core_res_tvalid  in  1, core_res_tready  out  1  core result stream.
REQ-008 SHALL have ports r0_tdata/r1_tdata  out  32, r0_tvalid/r1_tvalid  out  1, r0_tready/r1_tready  in  1  per-requester result return.
REQ-009 SHALL have ports busy  out  1 (state != IDLE), timeout_err  out  1 (sticky abort flag), err_clr  in  1 (clears timeout_err).
REQ-010 SHALL have ports res_cnt0/res_cnt1  out  16  delivered-result counters, wrap at 0xFFFF->0.

Function
REQ-011 SHALL implement FSM IDLE, STREAM, WAIT_RES; owner register (0/1) and last_grant register.
REQ-012 IDLE: all s*_tready=0, m_tvalid=0; if any s*_tvalid=1, latch owner and go STREAM next cycle.
REQ-013 Grant rule: single requester -> that one; both -> requester != last_grant (round-robin per packet).
REQ-014 STREAM: m_tdata/m_tvalid/m_tlast = owner's tdata/tvalid/tlast combinationally; owner tready = m_tready; non-owner tready=0.
REQ-015 STREAM -> WAIT_RES on cycle owner tvalid & m_tready & tlast all 1; no beat of a packet SHALL ever be interleaved with the other requester.
REQ-016 WAIT_RES: r<owner>_tvalid = core_res_tvalid, r<owner>_tdata = core_res_tdata, core_res_tready = r<owner>_tready; other r*_tvalid=0; m_tvalid=0.
REQ-017 WAIT_RES result handshake -> IDLE next cycle, last_grant <= owner, res_cnt<owner> += 1.
REQ-018 WAIT_RES cycle counter SHALL clear on entry and increment each cycle; reaching TIMEOUT_CYCLES without handshake -> timeout_err<=1, IDLE, last_grant <= owner, no counter increment.
REQ-019 In IDLE/STREAM core_res_tready SHALL be 1 and any core result SHALL be discarded (never presented on r*).
REQ-020 r*_tdata SHALL be 0 whenever the corresponding r*_tvalid=0.
REQ-021 err_clr=1 SHALL clear timeout_err next cycle; simultaneous timeout and err_clr -> timeout_err=1 (set wins).
REQ-022 Result handshake on the same cycle timeout count is reached -> handshake wins, no error.
REQ-023 Zero-length packet impossible: first accepted beat with tlast=1 is a complete 1-beat packet and SHALL go directly to WAIT_RES.

Reset
REQ-024 Reset assertion SHALL immediately (asynchronously) force IDLE, owner=0, last_grant=1, timeout counter=0, timeout_err=0, res_cnt0=res_cnt1=0.
REQ-025 During reset all outputs SHALL be 0 except none; s*_tready, m_tvalid, m_tlast, r*_tvalid, core_res_tready, busy all 0.
REQ-026 Reset mid-packet or mid-WAIT_RES SHALL abandon the transaction with no result delivered; first grant after reset goes to s0 on contention.

Verification
REQ-027 Both requesters valid after reset, 3-beat packets, m_tready=1 -> s0 granted first, beats appear on m_* in order, result 0x19 returned on r0 only, then s1 granted, res_cnt0=1, res_cnt1=1.
REQ-028 s1 streams with m_tready toggling 1/0, s0 asserts tvalid mid-packet -> s0_tready stays 0 until s1 result delivered; no beat interleave.
REQ-029 TIMEOUT_CYCLES=8, core never returns result -> timeout_err=1 exactly 8 cycles after WAIT_RES entry, busy=0 next cycle; err_clr pulse -> timeout_err=0.
REQ-030 r0_tready held 0 for 5 cycles with core_res_tvalid=1 -> core_res_tready=0 throughout, data 0x19 held stable, delivered on first r0_tready=1.
REQ-031 Async reset asserted mid-STREAM between clock edges -> all valids/readies 0 before next edge; spurious core result in IDLE consumed and not seen on r*.
REQ-032 Force res_cnt0 to 0xFFFF path (65536 s0 packets or preload in sim) -> next delivery wraps to 0x0000.
